// File: rtl/dt_pkg.sv
// Shared types and constants for the two-pass distance-transform engine:
// FSM encodings, neighbour identifiers and the metric selector.
package dt_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FWD, ST_BWD, ST_FIN} state_t;

    // Per-pixel micro-phase; LOAD uses only PH_RD (sti read) and PH_WR (pixel writes)
    typedef enum logic [2:0] {PH_RD, PH_CHK, PH_NBR, PH_ACC, PH_WR} phase_t;

    typedef enum logic [2:0] {NB_NW, NB_N, NB_NE, NB_W, NB_E, NB_SW, NB_S, NB_SE} nbr_t;

    localparam logic MODE_CHESS = 1'b0;
    localparam logic MODE_CITY  = 1'b1;

    // Forward pass visits NW,N,NE,W; backward pass mirrors it as SE,S,SW,E
    function automatic nbr_t slot_nbr(input logic bwd, input logic mode, input logic [1:0] slot);
        nbr_t n;
        if (mode == MODE_CITY) begin
            if (bwd) n = slot[0] ? NB_E : NB_S;
            else     n = slot[0] ? NB_W : NB_N;
        end else begin
            if (bwd) n = nbr_t'(3'd7 - {1'b0, slot});
            else     n = nbr_t'({1'b0, slot});
        end
        return n;
    endfunction

    function automatic logic [1:0] last_slot(input logic mode);
        return (mode == MODE_CITY) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/dt_nbr_min.sv
// Running-minimum accumulator over a pixel's neighbours, with a
// saturating +1 view of the current minimum.
module dt_nbr_min #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             acc_en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] min_inc
);

    localparam logic [PIX_W:0] SAT = {1'b0, {PIX_W{1'b1}}};
    localparam logic [PIX_W:0] INC = (PIX_W + 1)'(1);

    logic [PIX_W-1:0] acc_q;
    logic [PIX_W:0]   sum;

    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // only takes effect on an edge; state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rstn)                       acc_q <= '0;
        else if (clr)                    acc_q <= '1;
        else if (acc_en && din < acc_q)  acc_q <= din;
    end

    // One extra bit so that max+1 is seen as overflow before clamping
    assign sum     = {1'b0, acc_q} + INC;
    assign min_inc = (sum > SAT) ? SAT[PIX_W-1:0] : sum[PIX_W-1:0];

endmodule

// File: rtl/dt_engine.sv
// Two-pass distance-transform engine: unpacks the sti image into res, then
// runs forward and backward raster passes writing distances in place.
module dt_engine
    import dt_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int STI_W = 16,
    parameter int PIX_W = 8,
    localparam int SA_W = $clog2(IMG_W * IMG_H / STI_W),
    localparam int RA_W = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             sti_rd,
    output logic [SA_W-1:0]  sti_addr,
    input  logic [STI_W-1:0] sti_di,
    output logic             res_rd,
    output logic             res_wr,
    output logic [RA_W-1:0]  res_addr,
    output logic [PIX_W-1:0] res_do,
    input  logic [PIX_W-1:0] res_di
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = (STI_W > 1) ? $clog2(STI_W) : 1;

    localparam logic [RA_W-1:0] LAST  = RA_W'(IMG_W * IMG_H - 1);
    localparam logic [RA_W-1:0] ROW   = RA_W'(IMG_W);
    localparam logic [RA_W-1:0] ONE   = RA_W'(1);
    localparam logic [XW-1:0]   X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0]   Y_MAX = YW'(IMG_H - 1);
    localparam logic [BW-1:0]   B_MAX = BW'(STI_W - 1);

    state_t state, state_nx;
    phase_t phase, phase_nx;

    logic [RA_W-1:0]  addr;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [SA_W-1:0]  word_q;
    logic [BW-1:0]    bit_q;
    logic [STI_W-1:0] sti_q, sti_word, sti_sh;
    logic [PIX_W-1:0] centre_q, min_inc, bwd_val;
    logic [1:0]       slot_q;
    logic             mode_q, pend_valid, pend_rd;

    logic go, step_f, step_b, load_wr, slot_clr, slot_inc, acc_clr, centre_ld, nbr_slot, adv;
    logic bwd, last_px, x_lo, x_hi, y_lo, y_hi, nbr_ok;
    logic [RA_W-1:0] nbr_addr;
    nbr_t nid;

    assign bwd     = (state == ST_BWD);
    assign last_px = bwd ? (addr == '0) : (addr == LAST);
    assign x_lo    = (x != '0);
    assign x_hi    = (x != X_MAX);
    assign y_lo    = (y != '0);
    assign y_hi    = (y != Y_MAX);
    assign nid     = slot_nbr(bwd, mode_q, slot_q);

    // Out-of-image neighbours are flagged here and never read
    always_comb begin
        nbr_ok   = 1'b0;
        nbr_addr = addr;
        unique case (nid)
            NB_NW: begin nbr_ok = y_lo && x_lo; nbr_addr = addr - ROW - ONE; end
            NB_N:  begin nbr_ok = y_lo;         nbr_addr = addr - ROW;       end
            NB_NE: begin nbr_ok = y_lo && x_hi; nbr_addr = addr - ROW + ONE; end
            NB_W:  begin nbr_ok = x_lo;         nbr_addr = addr - ONE;       end
            NB_E:  begin nbr_ok = x_hi;         nbr_addr = addr + ONE;       end
            NB_SW: begin nbr_ok = y_hi && x_lo; nbr_addr = addr + ROW - ONE; end
            NB_S:  begin nbr_ok = y_hi;         nbr_addr = addr + ROW;       end
            NB_SE: begin nbr_ok = y_hi && x_hi; nbr_addr = addr + ROW + ONE; end
        endcase
    end

    // First pixel of a word takes sti_di directly; the rest use the latched copy
    assign sti_word = (bit_q == '0) ? sti_di : sti_q;
    assign sti_sh   = sti_word << bit_q;
    assign bwd_val  = (centre_q < min_inc) ? centre_q : min_inc;

    assign busy     = (state != ST_IDLE) && (state != ST_FIN);
    assign done     = (state == ST_FIN);
    assign sti_addr = word_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            phase <= PH_RD;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        sti_rd    = 1'b0;
        res_rd    = 1'b0;
        res_wr    = 1'b0;
        res_addr  = addr;
        res_do    = '0;
        go        = 1'b0;
        step_f    = 1'b0;
        step_b    = 1'b0;
        load_wr   = 1'b0;
        slot_clr  = 1'b0;
        slot_inc  = 1'b0;
        acc_clr   = 1'b0;
        centre_ld = 1'b0;
        nbr_slot  = 1'b0;
        adv       = 1'b0;
        unique case (state)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = ST_LOAD;
                    phase_nx = PH_RD;
                end
            end
            ST_LOAD: begin
                if (phase == PH_RD) begin
                    sti_rd   = 1'b1;
                    phase_nx = PH_WR;
                end else begin
                    res_wr  = 1'b1;
                    res_do  = PIX_W'(sti_sh[STI_W-1]);
                    load_wr = 1'b1;
                    step_f  = 1'b1;
                    if (bit_q == B_MAX) phase_nx = PH_RD;
                    if (addr == LAST) begin
                        state_nx = ST_FWD;
                        phase_nx = PH_RD;
                    end
                end
            end
            ST_FWD, ST_BWD: begin
                unique case (phase)
                    PH_RD: begin
                        res_rd   = 1'b1;
                        acc_clr  = 1'b1;
                        slot_clr = 1'b1;
                        phase_nx = PH_CHK;
                    end
                    PH_CHK: begin
                        centre_ld = 1'b1;
                        if (res_di == '0) adv = 1'b1;
                        else              phase_nx = PH_NBR;
                    end
                    PH_NBR: begin
                        nbr_slot = 1'b1;
                        res_rd   = nbr_ok;
                        res_addr = nbr_addr;
                        slot_inc = 1'b1;
                        if (slot_q == last_slot(mode_q)) phase_nx = PH_ACC;
                    end
                    PH_ACC: phase_nx = PH_WR;
                    PH_WR: begin
                        res_wr = 1'b1;
                        res_do = bwd ? bwd_val : min_inc;
                        adv    = 1'b1;
                    end
                    default: phase_nx = PH_RD;
                endcase
                if (adv) begin
                    phase_nx = PH_RD;
                    if (last_px)  state_nx = bwd ? ST_FIN : ST_BWD;
                    else if (bwd) step_b = 1'b1;
                    else          step_f = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr       <= '0;
            x          <= '0;
            y          <= '0;
            word_q     <= '0;
            bit_q      <= '0;
            sti_q      <= '0;
            centre_q   <= '0;
            slot_q     <= '0;
            mode_q     <= MODE_CHESS;
            pend_valid <= 1'b0;
            pend_rd    <= 1'b0;
        end else begin
            pend_valid <= nbr_slot;
            pend_rd    <= nbr_slot && nbr_ok;
            if (centre_ld) centre_q <= res_di;
            if (slot_clr)      slot_q <= '0;
            else if (slot_inc) slot_q <= slot_q + 2'd1;
            if (go) begin
                addr   <= '0;
                x      <= '0;
                y      <= '0;
                word_q <= '0;
                bit_q  <= '0;
                mode_q <= mode;
            end else begin
                if (step_f) begin
                    addr <= (addr == LAST) ? '0 : addr + ONE;
                    if (x == X_MAX) begin
                        x <= '0;
                        y <= (y == Y_MAX) ? '0 : y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end else if (step_b) begin
                    addr <= addr - ONE;
                    if (x == '0) begin
                        x <= X_MAX;
                        y <= y - YW'(1);
                    end else begin
                        x <= x - XW'(1);
                    end
                end
                if (load_wr) begin
                    if (bit_q == '0) sti_q <= sti_di;
                    if (bit_q == B_MAX) begin
                        bit_q  <= '0;
                        word_q <= word_q + SA_W'(1);
                    end else begin
                        bit_q <= bit_q + BW'(1);
                    end
                end
            end
        end
    end

    // Slot data returns one cycle after its strobe; skipped slots contribute 0
    dt_nbr_min #(.PIX_W(PIX_W)) u_min (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (acc_clr),
        .acc_en  (pend_valid),
        .din     (pend_rd ? res_di : '0),
        .min_inc (min_inc)
    );

endmodule

// File: tb/tb_dt_engine.sv
// Directed bench for dt_engine on a 16x16 image: an 8-bit instance and a
// 2-bit saturating instance run side by side on the same stimulus.
module tb_dt_engine;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int NPIX = W * H;
    localparam int SA_W = 4;
    localparam int RA_W = 8;

    logic clk, rstn, start, mode, fill_req;

    logic            busy8, done8, sti_rd8, res_rd8, res_wr8;
    logic [SA_W-1:0] sti_addr8;
    logic [15:0]     sti_di8;
    logic [RA_W-1:0] res_addr8;
    logic [7:0]      res_do8, res_di8;

    logic            busy2, done2, sti_rd2, res_rd2, res_wr2;
    logic [SA_W-1:0] sti_addr2;
    logic [15:0]     sti_di2;
    logic [RA_W-1:0] res_addr2;
    logic [1:0]      res_do2, res_di2;

    logic [15:0] rom  [0:H-1];
    logic [7:0]  ram8 [0:NPIX-1];
    logic [1:0]  ram2 [0:NPIX-1];

    int n_chk = 0;
    int n_err = 0;
    int clash = 0;

    dt_engine #(.IMG_W(W), .IMG_H(H), .STI_W(16), .PIX_W(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode),
        .busy(busy8), .done(done8),
        .sti_rd(sti_rd8), .sti_addr(sti_addr8), .sti_di(sti_di8),
        .res_rd(res_rd8), .res_wr(res_wr8), .res_addr(res_addr8),
        .res_do(res_do8), .res_di(res_di8)
    );

    dt_engine #(.IMG_W(W), .IMG_H(H), .STI_W(16), .PIX_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode),
        .busy(busy2), .done(done2),
        .sti_rd(sti_rd2), .sti_addr(sti_addr2), .sti_di(sti_di2),
        .res_rd(res_rd2), .res_wr(res_wr2), .res_addr(res_addr2),
        .res_do(res_do2), .res_di(res_di2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: one-cycle read latency, writes land on the edge
    always @(posedge clk) begin
        if (sti_rd8) sti_di8 <= rom[sti_addr8];
        if (sti_rd2) sti_di2 <= rom[sti_addr2];
        if (res_rd8) res_di8 <= ram8[res_addr8];
        if (res_rd2) res_di2 <= ram2[res_addr2];
        if (fill_req) begin
            for (int i = 0; i < NPIX; i++) begin
                ram8[i] <= 8'hA5;
                ram2[i] <= 2'b10;
            end
        end else begin
            if (res_wr8) ram8[res_addr8] <= res_do8;
            if (res_wr2) ram2[res_addr2] <= res_do2;
        end
        if ((res_rd8 && res_wr8) || (res_rd2 && res_wr2)) clash++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int img_px(input int x, input int y);
        logic [15:0] r;
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
        r = rom[y] << x;
        return int'(r[15]);
    endfunction

    // Brute-force distance to the nearest background pixel, outside counting as background
    function automatic int ref_px(input int x, input int y, input bit city, input int maxv);
        int best, dx, dy, d;
        if (img_px(x, y) == 0) return 0;
        best = 1000;
        for (int py = -1; py <= H; py++) begin
            for (int px = -1; px <= W; px++) begin
                if (img_px(px, py) == 0) begin
                    dx = (px > x) ? px - x : x - px;
                    dy = (py > y) ? py - y : y - py;
                    d  = city ? dx + dy : ((dx > dy) ? dx : dy);
                    if (d < best) best = d;
                end
            end
        end
        return (best > maxv) ? maxv : best;
    endfunction

    task automatic check_image(input string tag, input bit city);
        int bad8 = 0;
        int bad2 = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (int'(ram8[y*W+x]) != ref_px(x, y, city, 255)) bad8++;
                if (int'(ram2[y*W+x]) != ref_px(x, y, city, 3))   bad2++;
            end
        end
        check({tag, "_badpx8"}, bad8, 0);
        check({tag, "_badpx2"}, bad2, 0);
    endtask

    task automatic set_zero();
        for (int y = 0; y < H; y++) rom[y] = 16'h0000;
    endtask

    task automatic set_object(input bit hole);
        for (int y = 0; y < H; y++) rom[y] = (y == 0 || y == H-1) ? 16'h0000 : 16'h7FFE;
        if (hole) rom[4] = 16'h77FE;
    endtask

    task automatic kick(input bit m);
        @(negedge clk) fill_req = 1'b1;
        @(negedge clk) fill_req = 1'b0;
        start = 1'b1;
        mode  = m;
        @(negedge clk) start = 1'b0;
        check("start_busy", busy8, 1);
        check("start_done", done8, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done8 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done8"}, done8, 1);
        check({tag, "_done2"}, done2, 1);
        check({tag, "_busy"}, busy8, 0);
        check({tag, "_strobes"}, {sti_rd8, res_rd8, res_wr8, sti_rd2, res_rd2, res_wr2}, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mode = 1'b0; fill_req = 1'b0;
        set_zero();
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_strobes", {sti_rd8, res_rd8, res_wr8}, 0);
        check("rst_res_addr", res_addr8, 0);
        check("rst_sti_addr", sti_addr8, 0);
        rstn = 1'b1;

        // All-zero image
        set_zero();
        kick(1'b0);
        wait_done("zero");
        check_image("zero", 1'b0);

        // Single set pixel at (5,5), both metrics
        set_zero();
        rom[5] = 16'h0400;
        kick(1'b0);
        wait_done("dot_m0");
        check("dot_m0_85", ram8[85], 1);
        check_image("dot_m0", 1'b0);
        kick(1'b1);
        wait_done("dot_m1");
        check("dot_m1_85", ram8[85], 1);
        check_image("dot_m1", 1'b1);

        // Square object on rows/cols 1..14
        set_object(1'b0);
        kick(1'b0);
        wait_done("obj_m0");
        check("obj_m0_77", ram8[119], 7);
        check("obj_m0_11", ram8[17], 1);
        check("obj_m0_22", ram8[34], 2);
        check("obj_sat_77", ram2[119], 3);
        check("obj_sat_11", ram2[17], 1);
        check_image("obj_m0", 1'b0);
        kick(1'b1);
        wait_done("obj_m1");
        check("obj_m1_77", ram8[119], 7);
        check("obj_m1_11", ram8[17], 1);
        check("obj_m1_22", ram8[34], 2);
        check_image("obj_m1", 1'b1);

        // Object with a hole at (4,4): diagonal neighbour matters only in chessboard
        set_object(1'b1);
        kick(1'b0);
        wait_done("hole_m0");
        check("hole_m0_55", ram8[85], 1);
        check_image("hole_m0", 1'b0);
        kick(1'b1);
        wait_done("hole_m1");
        check("hole_m1_55", ram8[85], 2);
        check_image("hole_m1", 1'b1);

        // One-cycle reset in the middle of the forward pass, then a clean rerun
        set_object(1'b0);
        kick(1'b0);
        repeat (400) @(negedge clk);
        check("mid_busy", busy8, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_wr", res_wr8, 0);
        rstn = 1'b1;
        kick(1'b0);
        wait_done("rerun");
        check("rerun_77", ram8[119], 7);
        check_image("rerun", 1'b0);

        // Start pulse and mode change while busy must be ignored
        set_object(1'b1);
        kick(1'b1);
        repeat (600) @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk) start = 1'b0;
        wait_done("ignore");
        check("ignore_55", ram8[85], 2);
        check_image("ignore", 1'b1);

        check("rd_wr_exclusive", clash, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
